// File: rtl/gear_err_recovery.sv
// GeAr error recovery: recomputes the exact sum one window per cycle (K cycles), flags mismatching windows, holds the result until i_ready.
// Single outstanding transaction; o_ready only in IDLE. Optional error counter under GEAR_ERR_STATS_EN.
module gear_err_recovery #(
  parameter int R    = 16,
  parameter int P    = 16,
  parameter int IP_W = 16,
  parameter int OC_W = 48,
  localparam int L   = R + P,
  localparam int K   = 1 + (OC_W - L) / R
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [IP_W-1:0] i_p,
  input  logic [OC_W-1:0] i_c,
  input  logic [OC_W-1:0] i_s,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [OC_W-1:0] o_s,
  output logic [K-1:0]    o_err_mask,
  output logic            o_err
`ifdef GEAR_ERR_STATS_EN
  ,
  input  logic            i_cnt_clr,
  output logic [15:0]     o_err_cnt
`endif
);

  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [OC_W-1:0]  p_q, p_d;
  logic [OC_W-1:0]  c_q, c_d;
  logic [OC_W-1:0]  s_q, s_d;
  logic [OC_W-1:0]  o_s_q, o_s_d;
  logic [K-1:0]     mask_q, mask_d;

  logic signed [IP_W-1:0] p_signed;
  logic [OC_W-1:0]        p_ext;
  logic [L:0]             sum_lo;
  logic [R:0]             sum_win;
  int                     win_lo;

  assign p_signed = i_p;
  assign p_ext    = OC_W'(p_signed);

  // Window j>0 covers bits [P+j*R, P+(j+1)*R); window 0 is the full first sub-adder.
  always_comb begin
    win_lo  = P + int'(cnt_q) * R;
    sum_lo  = {1'b0, p_q[L-1:0]} + {1'b0, c_q[L-1:0]};
    sum_win = {1'b0, p_q[win_lo +: R]} + {1'b0, c_q[win_lo +: R]} + (R+1)'(carry_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    p_d     = p_q;
    c_d     = c_q;
    s_d     = s_q;
    o_s_d   = o_s_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          p_d     = p_ext;
          c_d     = i_c;
          s_d     = i_s;
          mask_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          o_s_d[L-1:0] = sum_lo[L-1:0];
          carry_d      = sum_lo[L];
          mask_d[0]    = (s_q[L-1:0] != sum_lo[L-1:0]);
        end else begin
          o_s_d[win_lo +: R] = sum_win[R-1:0];
          carry_d            = sum_win[R];
          mask_d[cnt_q]      = (s_q[win_lo +: R] != sum_win[R-1:0]);
        end
        if (cnt_q == CNT_W'(K - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      p_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      o_s_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      p_q     <= p_d;
      c_q     <= c_d;
      s_q     <= s_d;
      o_s_q   <= o_s_d;
      mask_q  <= mask_d;
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = (state_q == DONE);
  assign o_s        = o_s_q;
  assign o_err_mask = mask_q;
  assign o_err      = |mask_q;

`ifdef GEAR_ERR_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Clear takes priority over a same-cycle erroneous handshake.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_cnt_clr) begin
      err_cnt_d = '0;
    end else if (o_valid && i_ready && o_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_gear_err_recovery.sv
// Directed bench for gear_err_recovery at default parameters (K=2: windows [0,32) and [32,48)).
module tb_gear_err_recovery;

  localparam int R    = 16;
  localparam int P    = 16;
  localparam int IP_W = 16;
  localparam int OC_W = 48;
  localparam int K    = 1 + (OC_W - R - P) / R;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [IP_W-1:0] i_p = '0;
  logic [OC_W-1:0] i_c = '0;
  logic [OC_W-1:0] i_s = '0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [OC_W-1:0] o_s;
  logic [K-1:0]    o_err_mask;
  logic            o_err;
`ifdef GEAR_ERR_STATS_EN
  logic            cnt_clr = 1'b0;
  logic [15:0]     o_err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gear_err_recovery #(.R(R), .P(P), .IP_W(IP_W), .OC_W(OC_W)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_p        (i_p),
    .i_c        (i_c),
    .i_s        (i_s),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_s        (o_s),
    .o_err_mask (o_err_mask),
    .o_err      (o_err)
`ifdef GEAR_ERR_STATS_EN
    ,
    .i_cnt_clr  (cnt_clr),
    .o_err_cnt  (o_err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, measure latency, check result, optionally
  // stall in DONE with junk on the input side, then complete the handshake.
  task automatic run_txn(input string tag, input logic [IP_W-1:0] p, input logic [OC_W-1:0] c,
                         input logic [OC_W-1:0] s, input logic [OC_W-1:0] exp_s,
                         input logic [K-1:0] exp_m, input int hold, input bit clr);
    int cyc;
    cyc = 0;
    while (!o_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, ".ready_in"}, 64'(o_ready), 64'd1);
    i_p = p; i_c = c; i_s = s; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(K));
    chk({tag, ".o_s"}, 64'(o_s), 64'(exp_s));
    chk({tag, ".mask"}, 64'(o_err_mask), 64'(exp_m));
    chk({tag, ".err"}, 64'(o_err), 64'(|exp_m));
    chk({tag, ".ready_busy"}, 64'(o_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1; i_p = ~p; i_c = ~c; i_s = ~s;
      tick();
      chk({tag, ".hold_vld"}, 64'(o_valid), 64'd1);
      chk({tag, ".hold_rdy"}, 64'(o_ready), 64'd0);
      chk({tag, ".hold_s"}, 64'(o_s), 64'(exp_s));
      chk({tag, ".hold_mask"}, 64'(o_err_mask), 64'(exp_m));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
`ifdef GEAR_ERR_STATS_EN
    cnt_clr = clr;
`endif
    tick();
    i_ready = 1'b0;
`ifdef GEAR_ERR_STATS_EN
    cnt_clr = 1'b0;
`endif
    chk({tag, ".vld_drop"}, 64'(o_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(o_ready), 64'd1);
  endtask

  initial begin
    #12;
    chk("rst.ready", 64'(o_ready), 64'd1);
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.o_s", 64'(o_s), 64'd0);
    chk("rst.mask", 64'(o_err_mask), 64'd0);
    chk("rst.err", 64'(o_err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    run_txn("basic", 16'h0001, 48'h0000_0000_FFFF, 48'h0000_0001_0000,
            48'h0000_0001_0000, 2'b00, 0, 1'b0);
    run_txn("carry", 16'h0001, 48'hFFFF_FFFF_FFFF, 48'hFFFF_0000_0000,
            48'h0000_0000_0000, 2'b10, 0, 1'b0);
    run_txn("neg", 16'hFFFF, 48'h0000_0000_0005, 48'h0000_0000_0004,
            48'h0000_0000_0004, 2'b00, 0, 1'b0);
    run_txn("win0err", 16'h1234, 48'h0000_0000_0001, 48'h0000_0000_0000,
            48'h0000_0000_1235, 2'b01, 0, 1'b0);
    run_txn("botherr", 16'h8000, 48'h0000_0001_0000, 48'h1111_2222_3333,
            48'h0000_0000_8000, 2'b11, 0, 1'b0);
    run_txn("negext", 16'hFFFF, 48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF,
            48'hFFFF_FFFF_FFFF, 2'b00, 0, 1'b0);
    run_txn("bp", 16'h0001, 48'hFFFF_FFFF_FFFF, 48'hFFFF_0000_0000,
            48'h0000_0000_0000, 2'b10, 5, 1'b0);

    // Abort mid-RUN after window 0 has been written with an error flagged.
    i_p = 16'h0001; i_c = 48'h0000_0000_1234; i_s = 48'h0; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    chk("abort.ready", 64'(o_ready), 64'd1);
    chk("abort.valid", 64'(o_valid), 64'd0);
    chk("abort.o_s", 64'(o_s), 64'd0);
    chk("abort.mask", 64'(o_err_mask), 64'd0);
    chk("abort.err", 64'(o_err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("abort.idle_valid", 64'(o_valid), 64'd0);
    run_txn("after", 16'h0010, 48'h0000_1234_5678, 48'h0000_1234_5688,
            48'h0000_1234_5688, 2'b00, 0, 1'b0);

`ifdef GEAR_ERR_STATS_EN
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("stats.clr0", 64'(o_err_cnt), 64'd0);
    for (int t = 0; t < 3; t++) begin
      run_txn("stats.e", 16'h0001, 48'hFFFF_FFFF_FFFF, 48'hFFFF_0000_0000,
              48'h0000_0000_0000, 2'b10, 0, 1'b0);
      chk("stats.inc", 64'(o_err_cnt), 64'(t + 1));
    end
    run_txn("stats.ok", 16'h0001, 48'h0, 48'h1, 48'h1, 2'b00, 0, 1'b0);
    chk("stats.noinc", 64'(o_err_cnt), 64'd3);
    run_txn("stats.clr", 16'h0001, 48'hFFFF_FFFF_FFFF, 48'hFFFF_0000_0000,
            48'h0000_0000_0000, 2'b10, 0, 1'b1);
    chk("stats.clrwin", 64'(o_err_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
